bfis_topk: RTL and testbench
============================

BFIS_TOPK -- requirements
Module: bfis_topk

Interface
REQ-001 SHALL have parameter DIM, default 2: number of coordinates per vertex and per query.
REQ-002 SHALL have parameter K, default 4: number of nearest results kept, with K >= 1.
REQ-003 SHALL have parameter DATA_W, default 16: unsigned coordinate width.
REQ-004 SHALL have parameter ADDR_W, default 32: vertex address width.
REQ-005 SHALL derive DIST_W = 2*DATA_W + $clog2(DIM) + 1.
REQ-006 SHALL have port clk_in, input, 1 bit: the single clock.
REQ-007 SHALL have port rst_n_in, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port start_in, input, 1 bit: one-cycle pulse that loads the query and begins a search.
REQ-009 SHALL have port query_in, input, DIM x DATA_W: query coordinates, sampled on start_in.
REQ-010 SHALL have port vertex_in, input, DIM x DATA_W: candidate coordinates.
REQ-011 SHALL have port vertex_addr_in, input, ADDR_W: candidate identifier.
REQ-012 SHALL have port vertex_valid_in, input, 1 bit: candidate present.
REQ-013 SHALL have port vertex_last_in, input, 1 bit: final candidate of the stream, qualified by vertex_valid_in.
REQ-014 SHALL have port vertex_ready_out, output, 1 bit: candidate accepted when both valid and ready are high.
REQ-015 SHALL have port top_k_addr_out, output, K x ADDR_W: result addresses, index 0 nearest.
REQ-016 SHALL have port top_k_dist_out, output, K x DIST_W: result distances.
REQ-017 SHALL have port count_out, output, $clog2(K+1) bits: number of filled slots.
REQ-018 SHALL have port valid_out, output, 1 bit: results final.

Function
REQ-019 SHALL implement a state machine with states IDLE, STREAM, DRAIN and DONE.
REQ-020 SHALL make these transitions: IDLE->STREAM on start_in; STREAM->DRAIN on an accepted vertex with vertex_last_in; DRAIN->DONE when the pipeline is empty; DONE->STREAM on start_in.
REQ-021 SHALL drive vertex_ready_out high only in STREAM; the block never stalls inside STREAM.
REQ-022 SHALL, on start_in, latch query_in, set every slot to dist all-ones and addr 0, set count_out to 0, and clear valid_out.
REQ-023 SHALL ignore start_in while in STREAM or DRAIN.
REQ-024 SHALL compute, by default, the squared Euclidean distance: sum over d of (|v[d]-q[d]|)^2, zero-extended to DIST_W without overflow.
REQ-025 SHALL compute distance in a 2-stage pipeline: stage 1 absolute differences, stage 2 squares and sum.
REQ-026 SHALL insert in stage 3, in a single cycle, by parallel compare and shift of the sorted K-entry queue.
REQ-027 SHALL break distance ties by arrival order: an earlier vertex stays nearer.
REQ-028 SHALL discard a new vertex when the queue is full and its distance is >= the worst stored distance.
REQ-029 SHALL saturate count_out at K.
REQ-030 SHALL leave the unfilled slots of a stream with fewer than K vertices at all-ones/0.
REQ-031 SHALL assert valid_out exactly 3 cycles after the handshake of the last vertex.
REQ-032 SHALL hold valid_out high, with outputs stable, in DONE until the next start_in.
REQ-033 SHALL accept a zero-length search (start_in then vertex_last_in without any other vertex) as valid: the last vertex is still processed.

Reset
REQ-034 SHALL, on rst_n_in low at any time including mid-stream, immediately enter IDLE.
REQ-035 SHALL, in that reset, clear vertex_ready_out, valid_out and count_out, set all top_k_dist_out to all-ones and all top_k_addr_out to 0, and flush pipeline valids.
REQ-036 SHALL resume normal operation on the first clk_in edge after rst_n_in rises.

Configuration
REQ-037 SHALL, when macro BFIS_DIST_SEL_EN is defined, add input dist_mode_in (1 bit, latched on start_in): 0 selects squared L2, 1 selects L1 (sum of |v[d]-q[d]|).
REQ-038 SHALL, when BFIS_DIST_SEL_EN is undefined, omit dist_mode_in and support squared L2 only, with identical latency in both builds.

Verification
REQ-039 SHALL cover: DIM=2, K=4, query (5,7); vertices addr 10:(4,4), 11:(20,20), 12:(5,8), 13:(6,7) with last -> addr [12,13,10,11], dist [1,1,10,394], count_out 4, valid_out 3 cycles after last.
REQ-040 SHALL cover: the same stream plus addr 14:(30,30) before last -> addr 14 dropped, results unchanged.
REQ-041 SHALL cover: only addr 10:(4,4) with last -> count_out 1, slot0 = 10/10, slots 1..3 all-ones/0.
REQ-042 SHALL cover: rst_n_in pulsed low after two vertices -> outputs at reset values asynchronously, state IDLE, ready low; a new start_in then gives a clean search.
REQ-043 SHALL cover: with BFIS_DIST_SEL_EN and dist_mode_in=1, the REQ-039 stream -> dist [1,1,4,28], order [12,13,10,11].
REQ-044 SHALL cover: start_in pulsed during STREAM -> ignored, search completes unaffected.

Source files
------------

// File: rtl/bfis_topk.sv
// bfis_topk: streaming brute-force K-nearest search keeping a sorted top-K of a vertex stream.
// Optional BFIS_DIST_SEL_EN adds dist_mode_in (latched on start) to select L1 instead of squared L2.
module bfis_topk #(
   parameter int unsigned  DIM    = 2,
   parameter int unsigned  K      = 4,
   parameter int unsigned  DATA_W = 16,
   parameter int unsigned  ADDR_W = 32,
   localparam int unsigned DIST_W = 2*DATA_W + $clog2(DIM) + 1,
   localparam int unsigned CNT_W  = $clog2(K+1)
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  start_in,
`ifdef BFIS_DIST_SEL_EN
   input  logic                  dist_mode_in,
`endif
   input  logic [DIM*DATA_W-1:0] query_in,
   input  logic [DIM*DATA_W-1:0] vertex_in,
   input  logic [ADDR_W-1:0]     vertex_addr_in,
   input  logic                  vertex_valid_in,
   input  logic                  vertex_last_in,
   output logic                  vertex_ready_out,
   output logic [K*ADDR_W-1:0]   top_k_addr_out,
   output logic [K*DIST_W-1:0]   top_k_dist_out,
   output logic [CNT_W-1:0]      count_out,
   output logic                  valid_out
);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_e;

   state_e                     state_q, state_d;
   logic                       ready_q, ready_d;
   logic                       valid_q, valid_d;
   logic [DIM-1:0][DATA_W-1:0] query_q, query_d;
   logic                       mode_q, mode_d;

   logic                       s1_valid_q, s1_valid_d;
   logic                       s1_mode_q, s1_mode_d;
   logic [DIM-1:0][DATA_W-1:0] s1_absd_q, s1_absd_d;
   logic [ADDR_W-1:0]          s1_addr_q, s1_addr_d;

   logic                       s2_valid_q, s2_valid_d;
   logic [DIST_W-1:0]          s2_dist_q, s2_dist_d;
   logic [ADDR_W-1:0]          s2_addr_q, s2_addr_d;

   logic [K-1:0][DIST_W-1:0]   dist_q, dist_d;
   logic [K-1:0][ADDR_W-1:0]   addr_q, addr_d;
   logic [CNT_W-1:0]           count_q, count_d;

   logic                       start_ok_c;
   logic                       accept_c;
   logic                       pipe_empty_c;
   logic                       mode_sel_c;
   logic [DIM-1:0][DATA_W-1:0] vtx_c;
   logic [DIST_W-1:0]          sq_sum_c;
   logic [DIST_W-1:0]          ab_sum_c;
   logic [K-1:0]               closer_c;

`ifdef BFIS_DIST_SEL_EN
   assign mode_sel_c = dist_mode_in;
`else
   assign mode_sel_c = 1'b0;
`endif

   assign vtx_c        = vertex_in;
   assign start_ok_c   = start_in && ((state_q == IDLE) || (state_q == DONE));
   assign accept_c     = vertex_valid_in && ready_q;
   assign pipe_empty_c = !s1_valid_q && !s2_valid_q;

   // Control FSM; ready and valid are registered copies of the next state.
   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      query_d = query_q;
      mode_d  = mode_q;
      unique case (state_q)
         IDLE, DONE: if (start_in) state_d = STREAM;
         STREAM:     if (accept_c && vertex_last_in) state_d = DRAIN;
         DRAIN:      if (pipe_empty_c) state_d = DONE;
         default:    state_d = IDLE;
      endcase
      if (start_ok_c) begin
         query_d = query_in;
         mode_d  = mode_sel_c;
         valid_d = 1'b0;
      end else if (state_d == DONE) begin
         valid_d = 1'b1;
      end
      ready_d = (state_d == STREAM);
   end

   // Stage 1: per-coordinate absolute difference against the latched query.
   always_comb begin
      s1_valid_d = accept_c;
      s1_mode_d  = s1_mode_q;
      s1_addr_d  = s1_addr_q;
      s1_absd_d  = s1_absd_q;
      if (accept_c) begin
         s1_mode_d = mode_q;
         s1_addr_d = vertex_addr_in;
         for (int d = 0; d < int'(DIM); d++) begin
            s1_absd_d[d] = (vtx_c[d] >= query_q[d]) ? (vtx_c[d] - query_q[d])
                                                    : (query_q[d] - vtx_c[d]);
         end
      end
   end

   // Stage 2: reduce to a single distance; DIST_W leaves headroom so the sum cannot wrap.
   always_comb begin
      s2_valid_d = s1_valid_q;
      s2_addr_d  = s2_addr_q;
      s2_dist_d  = s2_dist_q;
      sq_sum_c   = '0;
      ab_sum_c   = '0;
      for (int d = 0; d < int'(DIM); d++) begin
         sq_sum_c = sq_sum_c + DIST_W'(s1_absd_q[d]) * DIST_W'(s1_absd_q[d]);
         ab_sum_c = ab_sum_c + DIST_W'(s1_absd_q[d]);
      end
      if (s1_valid_q) begin
         s2_addr_d = s1_addr_q;
         s2_dist_d = s1_mode_q ? ab_sum_c : sq_sum_c;
      end
   end

   // Stage 3: strict less-than keeps earlier arrivals ahead on ties; empty slots always yield.
   always_comb begin
      for (int i = 0; i < int'(K); i++) begin
         closer_c[i] = (CNT_W'(i) >= count_q) || (s2_dist_q < dist_q[i]);
      end
   end

   always_comb begin
      dist_d  = dist_q;
      addr_d  = addr_q;
      count_d = count_q;
      if (start_ok_c) begin
         dist_d  = '1;
         addr_d  = '0;
         count_d = '0;
      end else if (s2_valid_q) begin
         if (closer_c[0]) begin
            dist_d[0] = s2_dist_q;
            addr_d[0] = s2_addr_q;
         end
         for (int i = 1; i < int'(K); i++) begin
            if (closer_c[i]) begin
               dist_d[i] = closer_c[i-1] ? dist_q[i-1] : s2_dist_q;
               addr_d[i] = closer_c[i-1] ? addr_q[i-1] : s2_addr_q;
            end
         end
         if (closer_c[K-1] && (count_q != CNT_W'(K))) begin
            count_d = count_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q    <= IDLE;
         ready_q    <= 1'b0;
         valid_q    <= 1'b0;
         query_q    <= '0;
         mode_q     <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_mode_q  <= 1'b0;
         s1_addr_q  <= '0;
         s1_absd_q  <= '0;
         s2_valid_q <= 1'b0;
         s2_dist_q  <= '0;
         s2_addr_q  <= '0;
         dist_q     <= '1;
         addr_q     <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         ready_q    <= ready_d;
         valid_q    <= valid_d;
         query_q    <= query_d;
         mode_q     <= mode_d;
         s1_valid_q <= s1_valid_d;
         s1_mode_q  <= s1_mode_d;
         s1_addr_q  <= s1_addr_d;
         s1_absd_q  <= s1_absd_d;
         s2_valid_q <= s2_valid_d;
         s2_dist_q  <= s2_dist_d;
         s2_addr_q  <= s2_addr_d;
         dist_q     <= dist_d;
         addr_q     <= addr_d;
         count_q    <= count_d;
      end
   end

   assign vertex_ready_out = ready_q;
   assign valid_out        = valid_q;
   assign count_out        = count_q;
   assign top_k_addr_out   = addr_q;
   assign top_k_dist_out   = dist_q;

endmodule

// File: tb/tb_bfis_topk.sv
// Directed bench for bfis_topk: hand-computed top-K results, latency, reset and start handling.
module tb_bfis_topk;

   localparam int unsigned DIM    = 2;
   localparam int unsigned K      = 4;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DIST_W = 2*DATA_W + $clog2(DIM) + 1;
   localparam int unsigned CNT_W  = $clog2(K+1);

   localparam logic [DIST_W-1:0]   ONES       = '1;
   localparam logic [K*DIST_W-1:0] DIST_EMPTY = {K{ONES}};
   localparam logic [K*ADDR_W-1:0] ADDR_EMPTY = '0;
   localparam logic [K*ADDR_W-1:0] ADDR_A     = {32'd11, 32'd10, 32'd13, 32'd12};
   localparam logic [K*DIST_W-1:0] DIST_A     = {34'd394, 34'd10, 34'd1, 34'd1};
   localparam logic [K*ADDR_W-1:0] ADDR_ONE   = {32'd0, 32'd0, 32'd0, 32'd10};
   localparam logic [K*DIST_W-1:0] DIST_ONE   = {ONES, ONES, ONES, 34'd10};

   logic                  clk_in          = 1'b0;
   logic                  rst_n_in        = 1'b0;
   logic                  start_in        = 1'b0;
`ifdef BFIS_DIST_SEL_EN
   logic                  dist_mode_in    = 1'b0;
`endif
   logic [DIM*DATA_W-1:0] query_in        = '0;
   logic [DIM*DATA_W-1:0] vertex_in       = '0;
   logic [ADDR_W-1:0]     vertex_addr_in  = '0;
   logic                  vertex_valid_in = 1'b0;
   logic                  vertex_last_in  = 1'b0;
   logic                  vertex_ready_out;
   logic [K*ADDR_W-1:0]   top_k_addr_out;
   logic [K*DIST_W-1:0]   top_k_dist_out;
   logic [CNT_W-1:0]      count_out;
   logic                  valid_out;

   int n_vec = 0;
   int n_err = 0;

   bfis_topk #(.DIM(DIM), .K(K), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk_in           (clk_in),
      .rst_n_in         (rst_n_in),
      .start_in         (start_in),
`ifdef BFIS_DIST_SEL_EN
      .dist_mode_in     (dist_mode_in),
`endif
      .query_in         (query_in),
      .vertex_in        (vertex_in),
      .vertex_addr_in   (vertex_addr_in),
      .vertex_valid_in  (vertex_valid_in),
      .vertex_last_in   (vertex_last_in),
      .vertex_ready_out (vertex_ready_out),
      .top_k_addr_out   (top_k_addr_out),
      .top_k_dist_out   (top_k_dist_out),
      .count_out        (count_out),
      .valid_out        (valid_out)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic do_start(input logic [DATA_W-1:0] qx, input logic [DATA_W-1:0] qy);
      @(negedge clk_in);
      start_in = 1'b1;
      query_in = {qy, qx};
      @(negedge clk_in);
      start_in = 1'b0;
   endtask

   task automatic send_v(input logic [DATA_W-1:0] x, input logic [DATA_W-1:0] y,
                         input logic [ADDR_W-1:0] a, input logic last);
      vertex_in       = {y, x};
      vertex_addr_in  = a;
      vertex_valid_in = 1'b1;
      vertex_last_in  = last;
      @(negedge clk_in);
      vertex_valid_in = 1'b0;
      vertex_last_in  = 1'b0;
   endtask

   // Counts cycles from the last handshake edge until valid_out, bounded.
   task automatic wait_valid(input int lat0, output int lat);
      lat = lat0;
      while (!valid_out && lat < 20) begin
         @(negedge clk_in);
         lat++;
      end
   endtask

   task automatic send_stream_a();
      send_v(16'd4,  16'd4,  32'd10, 1'b0);
      send_v(16'd20, 16'd20, 32'd11, 1'b0);
      send_v(16'd5,  16'd8,  32'd12, 1'b0);
      send_v(16'd6,  16'd7,  32'd13, 1'b1);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk_in);
      n_vec++; if (vertex_ready_out !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", vertex_ready_out); end
      n_vec++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", valid_out); end
      n_vec++; if (count_out !== CNT_W'(0)) begin n_err++; $display("FAIL reset_count: got %0d want 0", count_out); end
      n_vec++; if (top_k_dist_out !== DIST_EMPTY) begin n_err++; $display("FAIL reset_dist: got %h want %h", top_k_dist_out, DIST_EMPTY); end
      n_vec++; if (top_k_addr_out !== ADDR_EMPTY) begin n_err++; $display("FAIL reset_addr: got %h want %h", top_k_addr_out, ADDR_EMPTY); end
      rst_n_in = 1'b1;
      @(negedge clk_in);
      n_vec++; if (vertex_ready_out !== 1'b0) begin n_err++; $display("FAIL idle_ready: got %b want 0", vertex_ready_out); end
   endtask

   task automatic test_basic();
      int lat;
      do_start(16'd5, 16'd7);
      n_vec++; if (vertex_ready_out !== 1'b1) begin n_err++; $display("FAIL basic_ready: got %b want 1", vertex_ready_out); end
      send_stream_a();
      n_vec++; if (vertex_ready_out !== 1'b0) begin n_err++; $display("FAIL basic_ready_drain: got %b want 0", vertex_ready_out); end
      wait_valid(0, lat);
      n_vec++; if (lat != 3) begin n_err++; $display("FAIL basic_latency: got %0d want 3", lat); end
      n_vec++; if (top_k_addr_out !== ADDR_A) begin n_err++; $display("FAIL basic_addr: got %h want %h", top_k_addr_out, ADDR_A); end
      n_vec++; if (top_k_dist_out !== DIST_A) begin n_err++; $display("FAIL basic_dist: got %h want %h", top_k_dist_out, DIST_A); end
      n_vec++; if (count_out !== CNT_W'(4)) begin n_err++; $display("FAIL basic_count: got %0d want 4", count_out); end
      repeat (4) @(negedge clk_in);
      n_vec++; if (valid_out !== 1'b1) begin n_err++; $display("FAIL done_hold_valid: got %b want 1", valid_out); end
      n_vec++; if (top_k_addr_out !== ADDR_A) begin n_err++; $display("FAIL done_hold_addr: got %h want %h", top_k_addr_out, ADDR_A); end
   endtask

   task automatic test_drop();
      int lat;
      do_start(16'd5, 16'd7);
      n_vec++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL restart_valid: got %b want 0", valid_out); end
      n_vec++; if (count_out !== CNT_W'(0)) begin n_err++; $display("FAIL restart_count: got %0d want 0", count_out); end
      n_vec++; if (top_k_dist_out !== DIST_EMPTY) begin n_err++; $display("FAIL restart_dist: got %h want %h", top_k_dist_out, DIST_EMPTY); end
      send_v(16'd4,  16'd4,  32'd10, 1'b0);
      send_v(16'd20, 16'd20, 32'd11, 1'b0);
      send_v(16'd5,  16'd8,  32'd12, 1'b0);
      send_v(16'd30, 16'd30, 32'd14, 1'b0);
      send_v(16'd6,  16'd7,  32'd13, 1'b1);
      wait_valid(0, lat);
      n_vec++; if (lat != 3) begin n_err++; $display("FAIL drop_latency: got %0d want 3", lat); end
      n_vec++; if (top_k_addr_out !== ADDR_A) begin n_err++; $display("FAIL drop_addr: got %h want %h", top_k_addr_out, ADDR_A); end
      n_vec++; if (top_k_dist_out !== DIST_A) begin n_err++; $display("FAIL drop_dist: got %h want %h", top_k_dist_out, DIST_A); end
      // Full queue: a tie with the worst entry and a farther one are both discarded.
      do_start(16'd5, 16'd7);
      send_v(16'd4,  16'd4,  32'd10, 1'b0);
      send_v(16'd20, 16'd20, 32'd11, 1'b0);
      send_v(16'd5,  16'd8,  32'd12, 1'b0);
      send_v(16'd6,  16'd7,  32'd13, 1'b0);
      send_v(16'd20, 16'd20, 32'd15, 1'b0);
      send_v(16'd30, 16'd30, 32'd14, 1'b1);
      wait_valid(0, lat);
      n_vec++; if (lat != 3) begin n_err++; $display("FAIL full_latency: got %0d want 3", lat); end
      n_vec++; if (top_k_addr_out !== ADDR_A) begin n_err++; $display("FAIL full_addr: got %h want %h", top_k_addr_out, ADDR_A); end
      n_vec++; if (top_k_dist_out !== DIST_A) begin n_err++; $display("FAIL full_dist: got %h want %h", top_k_dist_out, DIST_A); end
      n_vec++; if (count_out !== CNT_W'(4)) begin n_err++; $display("FAIL full_count: got %0d want 4", count_out); end
   endtask

   task automatic test_single();
      int lat;
      do_start(16'd5, 16'd7);
      send_v(16'd4, 16'd4, 32'd10, 1'b1);
      wait_valid(0, lat);
      n_vec++; if (lat != 3) begin n_err++; $display("FAIL single_latency: got %0d want 3", lat); end
      n_vec++; if (count_out !== CNT_W'(1)) begin n_err++; $display("FAIL single_count: got %0d want 1", count_out); end
      n_vec++; if (top_k_addr_out !== ADDR_ONE) begin n_err++; $display("FAIL single_addr: got %h want %h", top_k_addr_out, ADDR_ONE); end
      n_vec++; if (top_k_dist_out !== DIST_ONE) begin n_err++; $display("FAIL single_dist: got %h want %h", top_k_dist_out, DIST_ONE); end
   endtask

   task automatic test_start_ignored();
      int lat;
      do_start(16'd5, 16'd7);
      send_v(16'd4, 16'd4, 32'd10, 1'b0);
      start_in = 1'b1;
      query_in = '0;
      send_v(16'd20, 16'd20, 32'd11, 1'b0);
      start_in = 1'b0;
      send_v(16'd5, 16'd8, 32'd12, 1'b0);
      send_v(16'd6, 16'd7, 32'd13, 1'b1);
      start_in = 1'b1;
      @(negedge clk_in);
      start_in = 1'b0;
      wait_valid(1, lat);
      n_vec++; if (lat != 3) begin n_err++; $display("FAIL ignore_latency: got %0d want 3", lat); end
      n_vec++; if (top_k_addr_out !== ADDR_A) begin n_err++; $display("FAIL ignore_addr: got %h want %h", top_k_addr_out, ADDR_A); end
      n_vec++; if (top_k_dist_out !== DIST_A) begin n_err++; $display("FAIL ignore_dist: got %h want %h", top_k_dist_out, DIST_A); end
      n_vec++; if (count_out !== CNT_W'(4)) begin n_err++; $display("FAIL ignore_count: got %0d want 4", count_out); end
   endtask

   task automatic test_midstream_reset();
      int lat;
      do_start(16'd5, 16'd7);
      send_v(16'd4, 16'd4, 32'd10, 1'b0);
      send_v(16'd20, 16'd20, 32'd11, 1'b0);
      @(negedge clk_in);
      n_vec++; if (count_out !== CNT_W'(1)) begin n_err++; $display("FAIL prereset_count: got %0d want 1", count_out); end
      #2 rst_n_in = 1'b0;
      #1;
      n_vec++; if (vertex_ready_out !== 1'b0) begin n_err++; $display("FAIL arst_ready: got %b want 0", vertex_ready_out); end
      n_vec++; if (count_out !== CNT_W'(0)) begin n_err++; $display("FAIL arst_count: got %0d want 0", count_out); end
      n_vec++; if (top_k_dist_out !== DIST_EMPTY) begin n_err++; $display("FAIL arst_dist: got %h want %h", top_k_dist_out, DIST_EMPTY); end
      n_vec++; if (top_k_addr_out !== ADDR_EMPTY) begin n_err++; $display("FAIL arst_addr: got %h want %h", top_k_addr_out, ADDR_EMPTY); end
      @(negedge clk_in);
      rst_n_in = 1'b1;
      repeat (3) @(negedge clk_in);
      n_vec++; if (vertex_ready_out !== 1'b0) begin n_err++; $display("FAIL post_rst_ready: got %b want 0", vertex_ready_out); end
      n_vec++; if (count_out !== CNT_W'(0)) begin n_err++; $display("FAIL post_rst_count: got %0d want 0", count_out); end
      n_vec++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL post_rst_valid: got %b want 0", valid_out); end
      do_start(16'd5, 16'd7);
      send_stream_a();
      wait_valid(0, lat);
      n_vec++; if (lat != 3) begin n_err++; $display("FAIL clean_latency: got %0d want 3", lat); end
      n_vec++; if (top_k_addr_out !== ADDR_A) begin n_err++; $display("FAIL clean_addr: got %h want %h", top_k_addr_out, ADDR_A); end
      n_vec++; if (top_k_dist_out !== DIST_A) begin n_err++; $display("FAIL clean_dist: got %h want %h", top_k_dist_out, DIST_A); end
   endtask

`ifdef BFIS_DIST_SEL_EN
   task automatic test_l1();
      int lat;
      logic [K*DIST_W-1:0] exp_dist;
      exp_dist = {34'd28, 34'd4, 34'd1, 34'd1};
      dist_mode_in = 1'b1;
      do_start(16'd5, 16'd7);
      dist_mode_in = 1'b0;
      send_stream_a();
      wait_valid(0, lat);
      n_vec++; if (lat != 3) begin n_err++; $display("FAIL l1_latency: got %0d want 3", lat); end
      n_vec++; if (top_k_addr_out !== ADDR_A) begin n_err++; $display("FAIL l1_addr: got %h want %h", top_k_addr_out, ADDR_A); end
      n_vec++; if (top_k_dist_out !== exp_dist) begin n_err++; $display("FAIL l1_dist: got %h want %h", top_k_dist_out, exp_dist); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_drop();
      test_single();
      test_start_ignored();
      test_midstream_reset();
`ifdef BFIS_DIST_SEL_EN
      test_l1();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
